axis_selector_sequencer: RTL and testbench
==========================================

Name: axis_selector_sequencer

Overview:
Control block that owns the 32-bit routing word feeding the 16-to-6 AXIS stream selector in the RPSPMC PL.
- Accepts a requested routing word from the PS configuration register and validates every 4-bit source index against a populated-source mask.
- Applies the change only at a sample-sync boundary, so downstream consumers never see a mid-sample source switch.
- Blanks the affected output streams for a programmable settle window around the switch, covering the mux's one-cycle register stage and downstream pipelines.

Parameters:
N_OUT, 6, number of selector outputs (4-bit nibble each, bits 4*N_OUT-1:0)
BLANK_CYCLES, 4, cycles the affected outputs are blanked before the new word is driven (>=1)
SETTLE_CYCLES, 2, cycles blank is held after the new word is driven (>=1; covers mux register latency)
SYNC_TIMEOUT, 65535, max cycles to wait for sync_tick before a forced apply

Ports:
a_clk  in  1  system clock, 125 MHz
a_rst  in  1  synchronous, active-high reset
cfg_selector  in  32  requested routing word; nibble k = source index for output k+1; bits 31:24 ignored
cfg_src_mask  in  16  bit i = 1 means source stream i is populated/legal
cfg_force  in  1  level; while high, WAIT_SYNC proceeds without sync_tick
sync_tick  in  1  one-cycle sample-boundary strobe
err_clr  in  1  clears sticky error flags
axis_selector  out  32  applied routing word to the selector; bits 31:24 always 0
m_blank  out  N_OUT  per-output blank; consumer gates M_AXIS_k_tvalid low while set
busy  out  1  high whenever state != IDLE
err_invalid  out  1  sticky: a request was rejected for an illegal source index
err_timeout  out  1  sticky: apply forced by SYNC_TIMEOUT expiry
switch_count  out  16  number of completed switches, wraps at 0xFFFF->0

Behaviour:
Reset values:
- axis_selector=0 (all outputs from source 0); m_blank=0; busy=0; err_invalid=0; err_timeout=0; switch_count=0.
- Internal last_req=0; state=IDLE.
- Reset mid-operation aborts immediately, releases blank, and discards the pending request.

State machine (all outputs registered; busy decoded from the state register):
- IDLE:
  - If cfg_selector[23:0] != last_req: req<=cfg_selector[23:0]; last_req<=cfg_selector[23:0]; go to CHECK.
  - Changes to cfg_selector while not in IDLE are not captured; they are detected on return to IDLE.
- CHECK (1 cycle):
  - If any nibble k has cfg_src_mask[req[4k+3:4k]]==0: set err_invalid, go to IDLE; axis_selector unchanged.
  - Else if req==axis_selector[23:0]: go to IDLE with no blank and no count.
  - Else: diff[k]=1 for each nibble that differs; tcnt<=0; go to WAIT_SYNC.
- WAIT_SYNC:
  - On sync_tick or cfg_force: m_blank<=diff; cnt<=BLANK_CYCLES-1; go to BLANK.
  - Else if tcnt==SYNC_TIMEOUT-1: set err_timeout; take the same transition as sync.
  - Else tcnt++.
- BLANK:
  - When cnt==0: axis_selector[23:0]<=req; cnt<=SETTLE_CYCLES-1; go to SETTLE.
  - Else cnt--.
- SETTLE:
  - When cnt==0: m_blank<=0; switch_count<=switch_count+1; go to IDLE.
  - Else cnt--.

Timing and boundary rules:
- Latency from sync_tick to the new axis_selector is BLANK_CYCLES+1 cycles. m_blank asserts the cycle after sync_tick and deasserts SETTLE_CYCLES cycles after axis_selector updates.
- Unaffected outputs never see m_blank asserted.
- err_clr and an error-set condition in the same cycle: set wins.
- cfg_src_mask is sampled in CHECK only; later mask changes do not abort an accepted request.
- sync_tick arriving in any state other than WAIT_SYNC is ignored.

Decomposition:
- Shared package rpspmc_sel_pkg holds:
  - state enum (IDLE, CHECK, WAIT_SYNC, BLANK, SETTLE)
  - SEL_NIBBLE_W=4 and N_SRC=16
  - a nibble-extract function reused by CHECK and diff generation.
- One natural sub-module, sel_word_check: combinational validation of N_OUT nibbles against the mask, plus the diff vector versus the applied word. Keep it separate so it can be unit-tested.

Test Plan:
- Reset, then cfg_selector=0x00543210, mask=0xFFFF, sync_tick 10 cycles after capture -> m_blank=6'b111110 after the tick; axis_selector=0x00543210 exactly 5 cycles after the tick; blank low 2 cycles later; switch_count=1.
- Mask=0x00FF, cfg_selector=0x00000009 -> err_invalid=1, axis_selector unchanged, m_blank never asserts; err_clr -> err_invalid=0.
- No sync_tick, cfg_force=0, new word -> after 65535 WAIT_SYNC cycles err_timeout=1 and the switch completes.
- cfg_selector rewritten to 0x00000011 while in BLANK -> first switch completes, then a second switch to 0x00000011 occurs; switch_count=2.
- a_rst asserted in SETTLE -> next cycle axis_selector=0, m_blank=0, busy=0, switch_count=0.
- cfg_selector set equal to the applied word with only bits 31:24 changed -> no capture, busy stays 0.

Source files
------------

// File: rtl/axis_selector_sequencer_pkg.sv
// Shared definitions for the AXIS stream selector sequencer.
//   - sequencer state encoding
//   - nibble geometry of the routing word and number of selectable sources
//   - sel_nibble(): extract source index k from a routing word
package rpspmc_sel_pkg;

    localparam int unsigned SEL_NIBBLE_W = 4;
    localparam int unsigned N_SRC        = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_SYNC,
        BLANK,
        SETTLE
    } sel_state_t;

    // Shift rather than indexed part-select so the index width never has to
    // match the word width.
    function automatic logic [SEL_NIBBLE_W-1:0] sel_nibble(input logic [31:0] word,
                                                           input int unsigned k);
        logic [31:0] sh;
        sh = word >> (k * SEL_NIBBLE_W);
        return sh[SEL_NIBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/axis_selector_sequencer_sel_word_check.sv
// sel_word_check: combinational validation of a requested routing word.
// Ports:
//   req_word     in  32     requested routing word (nibble k = source for output k+1)
//   src_mask     in  16     bit i set = source i is populated
//   applied_word in  32     routing word currently driven to the selector
//   valid        out 1      every used nibble names a populated source
//   diff         out N_OUT  bit k set = nibble k differs from the applied word
module sel_word_check
    import rpspmc_sel_pkg::*;
#(
    parameter int unsigned N_OUT = 6
) (
    input  logic [31:0]      req_word,
    input  logic [N_SRC-1:0] src_mask,
    input  logic [31:0]      applied_word,
    output logic             valid,
    output logic [N_OUT-1:0] diff
);

    logic [N_OUT-1:0] nibble_ok;

    for (genvar k = 0; k < N_OUT; k++) begin : g_nib
        assign nibble_ok[k] = src_mask[sel_nibble(req_word, k)];
        assign diff[k]      = sel_nibble(req_word, k) != sel_nibble(applied_word, k);
    end

    assign valid = &nibble_ok;

endmodule

// File: rtl/axis_selector_sequencer.sv
// axis_selector_sequencer: owns the routing word of the 16-to-6 AXIS selector.
// A new request is captured when cfg_selector changes, validated against the
// populated-source mask, then applied at a sync_tick boundary with the
// affected outputs blanked for BLANK_CYCLES before and SETTLE_CYCLES after.
// Ports:
//   a_clk, a_rst   clock, synchronous active-high reset
//   cfg_selector   requested routing word (bits above 4*N_OUT ignored)
//   cfg_src_mask   populated-source mask, sampled only in CHECK
//   cfg_force      level, lets WAIT_SYNC proceed without sync_tick
//   sync_tick      sample-boundary strobe
//   err_clr        clears sticky errors (an error set in the same cycle wins)
//   axis_selector  applied routing word (upper bits 0)
//   m_blank        per-output blank
//   busy           state != IDLE
//   err_invalid    sticky: request rejected for an unpopulated source
//   err_timeout    sticky: apply forced by SYNC_TIMEOUT expiry
//   switch_count   completed switches, wrapping
module axis_selector_sequencer
    import rpspmc_sel_pkg::*;
#(
    parameter int unsigned N_OUT         = 6,
    parameter int unsigned BLANK_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SYNC_TIMEOUT  = 65535
) (
    input  logic             a_clk,
    input  logic             a_rst,
    input  logic [31:0]      cfg_selector,
    input  logic [15:0]      cfg_src_mask,
    input  logic             cfg_force,
    input  logic             sync_tick,
    input  logic             err_clr,
    output logic [31:0]      axis_selector,
    output logic [N_OUT-1:0] m_blank,
    output logic             busy,
    output logic             err_invalid,
    output logic             err_timeout,
    output logic [15:0]      switch_count
);

    localparam int unsigned SEL_W   = N_OUT * SEL_NIBBLE_W;
    localparam int unsigned CNT_MAX = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned TO_W    = $clog2(SYNC_TIMEOUT + 1);

    sel_state_t       state_q, state_n;
    logic [SEL_W-1:0] req_q, req_n;
    logic [SEL_W-1:0] last_req_q, last_req_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [N_OUT-1:0] diff_q, diff_n;
    logic [N_OUT-1:0] blank_q, blank_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [TO_W-1:0]  tcnt_q, tcnt_n;
    logic             err_inv_q, err_inv_n;
    logic             err_to_q, err_to_n;
    logic [15:0]      count_q, count_n;

    logic             chk_valid;
    logic [N_OUT-1:0] chk_diff;
    logic             sync_go;

    sel_word_check #(.N_OUT(N_OUT)) u_check (
        .req_word     (32'(req_q)),
        .src_mask     (cfg_src_mask),
        .applied_word (32'(sel_q)),
        .valid        (chk_valid),
        .diff         (chk_diff)
    );

    if (SEL_W < 32) begin : g_unused_hi
        logic unused_sel_hi;
        assign unused_sel_hi = ^cfg_selector[31:SEL_W];
    end

    assign sync_go = sync_tick | cfg_force;

    always_comb begin
        state_n    = state_q;
        req_n      = req_q;
        last_req_n = last_req_q;
        sel_n      = sel_q;
        diff_n     = diff_q;
        blank_n    = blank_q;
        cnt_n      = cnt_q;
        tcnt_n     = tcnt_q;
        count_n    = count_q;
        err_inv_n  = err_inv_q;
        err_to_n   = err_to_q;

        // Clear first so that any set below overrides it.
        if (err_clr) begin
            err_inv_n = 1'b0;
            err_to_n  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_selector[SEL_W-1:0] != last_req_q) begin
                    req_n      = cfg_selector[SEL_W-1:0];
                    last_req_n = cfg_selector[SEL_W-1:0];
                    state_n    = CHECK;
                end
            end
            CHECK: begin
                if (!chk_valid) begin
                    err_inv_n = 1'b1;
                    state_n   = IDLE;
                end else if (req_q == sel_q) begin
                    state_n = IDLE;
                end else begin
                    diff_n  = chk_diff;
                    tcnt_n  = '0;
                    state_n = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (sync_go || tcnt_q == TO_W'(SYNC_TIMEOUT - 1)) begin
                    if (!sync_go) begin
                        err_to_n = 1'b1;
                    end
                    blank_n = diff_q;
                    cnt_n   = CNT_W'(BLANK_CYCLES - 1);
                    state_n = BLANK;
                end else begin
                    tcnt_n = tcnt_q + TO_W'(1);
                end
            end
            BLANK: begin
                if (cnt_q == '0) begin
                    sel_n   = req_q;
                    cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
                    state_n = SETTLE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    blank_n = '0;
                    count_n = count_q + 16'd1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            last_req_q <= '0;
            sel_q      <= '0;
            diff_q     <= '0;
            blank_q    <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            count_q    <= '0;
            err_inv_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_n;
            req_q      <= req_n;
            last_req_q <= last_req_n;
            sel_q      <= sel_n;
            diff_q     <= diff_n;
            blank_q    <= blank_n;
            cnt_q      <= cnt_n;
            tcnt_q     <= tcnt_n;
            count_q    <= count_n;
            err_inv_q  <= err_inv_n;
            err_to_q   <= err_to_n;
        end
    end

    assign axis_selector = 32'(sel_q);
    assign m_blank       = blank_q;
    assign busy          = (state_q != IDLE);
    assign err_invalid   = err_inv_q;
    assign err_timeout   = err_to_q;
    assign switch_count  = count_q;

endmodule

// File: tb/tb_axis_selector_sequencer.sv
// Self-checking bench for axis_selector_sequencer: table vectors, directed
// corner sequences and randomized transactions against a timeline model.
module tb_axis_selector_sequencer;

    localparam int N_OUT = 6;
    localparam int B     = 4;
    localparam int S     = 2;
    localparam int TO    = 65535;

    logic        a_clk = 1'b0;
    logic        a_rst = 1'b1;
    logic [31:0] cfg_selector = '0;
    logic [15:0] cfg_src_mask = 16'hFFFF;
    logic        cfg_force = 1'b0;
    logic        sync_tick = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] axis_selector;
    logic [5:0]  m_blank;
    logic        busy;
    logic        err_invalid;
    logic        err_timeout;
    logic [15:0] switch_count;

    axis_selector_sequencer #(
        .N_OUT(N_OUT), .BLANK_CYCLES(B), .SETTLE_CYCLES(S), .SYNC_TIMEOUT(TO)
    ) dut (
        .a_clk(a_clk), .a_rst(a_rst), .cfg_selector(cfg_selector),
        .cfg_src_mask(cfg_src_mask), .cfg_force(cfg_force), .sync_tick(sync_tick),
        .err_clr(err_clr), .axis_selector(axis_selector), .m_blank(m_blank),
        .busy(busy), .err_invalid(err_invalid), .err_timeout(err_timeout),
        .switch_count(switch_count)
    );

    always #4 a_clk = ~a_clk;

    int checks = 0;
    int errors = 0;

    // Model of the architectural state
    logic [31:0] m_axis = '0;
    logic [15:0] m_cnt  = '0;
    logic [23:0] m_last = '0;
    logic        m_einv = 1'b0;
    logic        m_eto  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    task automatic chk_all(input logic [5:0] exp_blank, input logic exp_busy);
        chk("axis_selector", axis_selector, m_axis);
        chk("m_blank", 32'(m_blank), 32'(exp_blank));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("err_invalid", 32'(err_invalid), 32'(m_einv));
        chk("err_timeout", 32'(err_timeout), 32'(m_eto));
        chk("switch_count", 32'(switch_count), 32'(m_cnt));
    endtask

    // One request from IDLE. kind: 0 = sync_tick after d WAIT_SYNC cycles,
    // 1 = cfg_force after d cycles, 2 = no strobe (timeout).
    // Expected outputs come from a timeline: edge 0 captures, edge 1 decides,
    // edge ts applies the strobe, ts+B drives the word, ts+B+S ends the blank.
    task automatic run_txn(input logic [31:0] sel, input logic [15:0] mask, input int d,
                           input int kind, input bit clr, input bit noise,
                           input bit mid_en, input logic [31:0] midsel,
                           output logic [5:0] blank_seen);
        logic [23:0] req;
        logic [5:0]  diff;
        logic [5:0]  exp_blank;
        bit          invalid, same;
        int          ts, last_n;
        req = sel[23:0];
        blank_seen = '0;
        invalid = 1'b0;
        diff = '0;
        for (int k = 0; k < N_OUT; k++) begin
            logic [3:0] nr, na;
            nr = 4'((req >> (4 * k)) & 24'hF);
            na = 4'((m_axis >> (4 * k)) & 32'hF);
            if (!mask[nr]) invalid = 1'b1;
            diff[k] = (nr != na);
        end
        same = (req == m_axis[23:0]);
        cfg_selector = sel;
        cfg_src_mask = mask;
        if (req == m_last) begin
            for (int n = 0; n < 3; n++) begin
                step();
                chk_all(6'b0, 1'b0);
                blank_seen |= m_blank;
            end
            return;
        end
        m_last = req;
        ts = (kind == 2) ? 2 + TO - 1 : 2 + d;
        last_n = (invalid || same) ? 1 : ts + B + S;
        for (int n = 0; n <= last_n; n++) begin
            err_clr   = clr && (n == 1);
            sync_tick = (kind == 0 && n == ts) ||
                        (noise && (n == 1 || n > ts) && ($urandom % 2 == 1));
            cfg_force = (kind == 1 && n == ts);
            if (mid_en && n == ts + 2) cfg_selector = midsel;
            if (n >= 2) cfg_src_mask = noise ? 16'($urandom) : mask;
            step();
            if (n == 1) begin
                if (clr) begin
                    m_einv = 1'b0;
                    m_eto  = 1'b0;
                end
                if (invalid) m_einv = 1'b1;
            end
            if (kind == 2 && n == ts && !invalid && !same) m_eto = 1'b1;
            if (!invalid && !same) begin
                if (n == ts + B) m_axis = {8'h00, req};
                if (n == ts + B + S) m_cnt = m_cnt + 16'd1;
            end
            exp_blank = (!invalid && !same && n >= ts && n < ts + B + S) ? diff : 6'b0;
            blank_seen |= m_blank;
            if (!(kind == 2 && n > 3 && n < ts - 2))
                chk_all(exp_blank, n < last_n);
        end
        err_clr   = 1'b0;
        sync_tick = 1'b0;
        cfg_force = 1'b0;
    endtask

    typedef struct {
        logic [31:0] sel;
        logic [15:0] mask;
        int          d;
        int          kind;
        bit          clr;
        logic [31:0] exp_axis;
        logic [5:0]  exp_blank;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [5:0] bs;
        // capture at edge 0, tick sampled 10 edges later -> d = 8
        vecs[0] = '{32'h00543210, 16'hFFFF, 8, 0, 0, 32'h00543210, 6'b111110, 1'b0, 16'd1};
        vecs[1] = '{32'h00000009, 16'h00FF, 3, 0, 0, 32'h00543210, 6'b000000, 1'b1, 16'd1};
        vecs[2] = '{32'h00000003, 16'h00FF, 3, 0, 1, 32'h00000003, 6'b111111, 1'b0, 16'd2};
        vecs[3] = '{32'hFF000003, 16'hFFFF, 3, 0, 0, 32'h00000003, 6'b000000, 1'b0, 16'd2};
        vecs[4] = '{32'h00000013, 16'hFFFF, 0, 1, 0, 32'h00000013, 6'b000010, 1'b0, 16'd3};
        vecs[5] = '{32'h00FFFFFF, 16'h7FFF, 2, 0, 0, 32'h00000013, 6'b000000, 1'b1, 16'd3};
        vecs[6] = '{32'h00000013, 16'hFFFF, 2, 0, 0, 32'h00000013, 6'b000000, 1'b1, 16'd3};

        // Reset state
        repeat (3) step();
        chk_all(6'b0, 1'b0);
        a_rst = 1'b0;
        step();
        chk_all(6'b0, 1'b0);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].sel, vecs[i].mask, vecs[i].d, vecs[i].kind, vecs[i].clr,
                    1'b0, 1'b0, '0, bs);
            chk($sformatf("vec%0d axis", i), axis_selector, vecs[i].exp_axis);
            chk($sformatf("vec%0d blank", i), 32'(bs), 32'(vecs[i].exp_blank));
            chk($sformatf("vec%0d err_invalid", i), 32'(err_invalid), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d count", i), 32'(switch_count), 32'(vecs[i].exp_cnt));
        end

        // Timeout: no strobe, apply forced after SYNC_TIMEOUT WAIT_SYNC cycles
        run_txn(32'h00000555, 16'hFFFF, 0, 2, 1'b0, 1'b0, 1'b0, '0, bs);
        chk("timeout err", 32'(err_timeout), 32'd1);
        chk("timeout axis", axis_selector, 32'h00000555);
        chk("timeout count", 32'(switch_count), 32'd4);

        // err_clr during a rejecting CHECK: set wins for err_invalid
        run_txn(32'h00000F00, 16'h00FF, 0, 0, 1'b1, 1'b0, 1'b0, '0, bs);
        chk("clr/set err_invalid", 32'(err_invalid), 32'd1);
        chk("clr err_timeout", 32'(err_timeout), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 150; i++) begin
            logic [31:0] sel;
            logic [15:0] mask;
            sel  = $urandom;
            mask = ($urandom % 4 == 0) ? 16'($urandom) : 16'hFFFF;
            if ($urandom % 8 == 0) sel = {8'($urandom), m_last};
            run_txn(sel, mask, int'($urandom % 12), int'($urandom % 2),
                    ($urandom % 5 == 0), 1'b1, 1'b0, '0, bs);
        end

        // Reset while in SETTLE
        cfg_selector = 32'h00000777;
        cfg_src_mask = 16'hFFFF;
        step();
        step();
        sync_tick = 1'b1;
        step();
        sync_tick = 1'b0;
        repeat (5) step();
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset axis", axis_selector, 32'h00000777);
        a_rst = 1'b1;
        cfg_selector = '0;
        step();
        a_rst = 1'b0;
        m_axis = '0; m_cnt = '0; m_last = '0; m_einv = 1'b0; m_eto = 1'b0;
        chk_all(6'b0, 1'b0);

        // Rewrite during BLANK is picked up only after the first switch
        run_txn(32'h00000022, 16'hFFFF, 2, 0, 1'b0, 1'b0, 1'b1, 32'h00000011, bs);
        run_txn(32'h00000011, 16'hFFFF, 1, 0, 1'b0, 1'b0, 1'b0, '0, bs);
        chk("rewrite axis", axis_selector, 32'h00000011);
        chk("rewrite count", 32'(switch_count), 32'd2);

        // Only ignored upper bits change: no capture
        run_txn(32'h7E000011, 16'hFFFF, 1, 0, 1'b0, 1'b0, 1'b0, '0, bs);
        chk("upper-only busy", 32'(busy), 32'd0);
        chk("upper-only count", 32'(switch_count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
